// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: read-owner encoding
// and default starvation parameters.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    localparam int DEFAULT_STARVE_LIMIT = 8;
    localparam int DEFAULT_CNT_W        = 4;

    function automatic logic isRead(input logic ce, input logic [3:0] we);
        return ce && (we == 4'b0000);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core, host and memory-side signals around the data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic                  core_ce;
    logic [DATA_W/8-1:0]   core_we;
    logic [ADDR_W-1:0]     core_addr;
    logic [DATA_W-1:0]     core_d;
    logic [DATA_W-1:0]     core_q;
    logic                  core_stall;

    logic                  host_req;
    logic [DATA_W/8-1:0]   host_we;
    logic [ADDR_W-1:0]     host_addr;
    logic [DATA_W-1:0]     host_d;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [DATA_W-1:0]     host_q;

    logic                  mem_ce;
    logic [DATA_W/8-1:0]   mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_d;
    logic [DATA_W-1:0]     mem_q;

    modport slave (
        input  core_ce, core_we, core_addr, core_d,
        output core_q, core_stall,
        input  host_req, host_we, host_addr, host_d,
        output host_gnt, host_rvalid, host_q,
        output mem_ce, mem_we, mem_addr, mem_d,
        input  mem_q
    );

    modport master (
        output core_ce, core_we, core_addr, core_d,
        input  core_q, core_stall,
        output host_req, host_we, host_addr, host_d,
        input  host_gnt, host_rvalid, host_q,
        input  mem_ce, mem_we, mem_addr, mem_d,
        output mem_q
    );

endinterface

// File: rtl/dmem_starve_counter.sv
// Counts cycles the host has been kept waiting and raises a force flag once
// the wait reaches STARVE_LIMIT.
module dmem_starve_counter #(
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_host_req,
    input  logic i_host_gnt,
    output logic o_force
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_wait_cnt;

    // A withdrawn request forfeits its accumulated wait just like a granted one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (i_host_gnt || !i_host_req) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != LIMIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign o_force = (r_wait_cnt == LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core LSU (priority) and a
// host requester, routing read data back to whoever issued the read.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    dmem_port_arbiter_if.slave bus
);

    logic                w_force;
    logic                w_host_sel;
    logic                w_mem_ce;
    logic                w_core_stall;
    logic [DATA_W/8-1:0] w_mem_we;
    owner_e              w_rd_owner_nxt;

    owner_e              r_rd_owner;
    logic                r_hold_vld;
    logic [DATA_W-1:0]   r_hold_q;
    logic                r_host_rvalid;
    logic [DATA_W-1:0]   r_host_q;

    dmem_starve_counter #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_host_req (bus.host_req),
        .i_host_gnt (w_host_sel),
        .o_force    (w_force)
    );

    // Grant is decided combinationally; reset blocks all memory activity.
    always_comb begin
        w_host_sel   = 1'b0;
        w_mem_ce     = 1'b0;
        w_core_stall = 1'b0;
        if (reset_n) begin
            if (w_force && bus.host_req) begin
                w_host_sel   = 1'b1;
                w_mem_ce     = 1'b1;
                w_core_stall = bus.core_ce;
            end else if (bus.core_ce) begin
                w_mem_ce     = 1'b1;
            end else if (bus.host_req) begin
                w_host_sel   = 1'b1;
                w_mem_ce     = 1'b1;
            end
        end
    end

    assign w_mem_we = !w_mem_ce ? '0 : (w_host_sel ? bus.host_we : bus.core_we);

    assign bus.mem_ce     = w_mem_ce;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_host_sel ? bus.host_addr : bus.core_addr;
    assign bus.mem_d      = w_host_sel ? bus.host_d : bus.core_d;
    assign bus.host_gnt   = w_host_sel;
    assign bus.core_stall = w_core_stall;

    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (isRead(w_mem_ce, w_mem_we)) begin
            w_rd_owner_nxt = w_host_sel ? OWN_HOST : OWN_CORE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // A core read landing during a stall is parked so the frozen core sees it afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_vld <= 1'b0;
            r_hold_q   <= '0;
        end else if (r_rd_owner == OWN_CORE && w_core_stall) begin
            r_hold_vld <= 1'b1;
            r_hold_q   <= bus.mem_q;
        end else if (!w_core_stall) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign bus.core_q = r_hold_vld ? r_hold_q : bus.mem_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_host_rvalid <= 1'b0;
            r_host_q      <= '0;
        end else begin
            r_host_rvalid <= (r_rd_owner == OWN_HOST);
            if (r_rd_owner == OWN_HOST) begin
                r_host_q <= bus.mem_q;
            end
        end
    end

    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_q      = r_host_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: grant-mux vector table plus
// directed sequences for starvation, read hold, conflicts and reset.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (8),
        .CNT_W        (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural single-port RAM with one-cycle read latency and byte writes.
    logic [31:0] memArray [0:255];

    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we == 4'b0000) begin
                bus.mem_q <= memArray[bus.mem_addr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_we[b]) memArray[bus.mem_addr[7:0]][8*b +: 8] = bus.mem_d[8*b +: 8];
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cCe;
        logic [3:0]  cWe;
        logic [29:0] cAddr;
        logic [31:0] cD;
        logic        hReq;
        logic [3:0]  hWe;
        logic [29:0] hAddr;
        logic [31:0] hD;
        logic        eCe;
        logic [3:0]  eWe;
        logic [29:0] eAddr;
        logic [31:0] eD;
        logic        eGnt;
        logic        eStall;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic cCe, input logic [3:0] cWe, input logic [29:0] cAddr,
                                 input logic [31:0] cD, input logic hReq, input logic [3:0] hWe,
                                 input logic [29:0] hAddr, input logic [31:0] hD);
        bus.core_ce   = cCe;
        bus.core_we   = cWe;
        bus.core_addr = cAddr;
        bus.core_d    = cD;
        bus.host_req  = hReq;
        bus.host_we   = hWe;
        bus.host_addr = hAddr;
        bus.host_d    = hD;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // With inputs held, the host must be forced in on exactly the 9th waiting cycle.
    task automatic runToForce(input string tag);
        for (int i = 1; i <= 9; i++) begin
            #1;
            checkOutput({tag, "_gnt"}, 32'(bus.host_gnt), 32'(i == 9));
            checkOutput({tag, "_stall"}, 32'(bus.core_stall), 32'(i == 9));
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memArray[i] = 32'h0;
        memArray[8'h20] = 32'h12345678;

        vecs[0] = '{1'b0, 4'h0, 30'h01, 32'h11, 1'b0, 4'h0, 30'h02, 32'h22, 1'b0, 4'h0, 30'h01, 32'h11, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'h0, 30'h05, 32'h55, 1'b0, 4'h0, 30'h02, 32'h22, 1'b1, 4'h0, 30'h05, 32'h55, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'h3, 30'h06, 32'h66, 1'b0, 4'h0, 30'h02, 32'h22, 1'b1, 4'h3, 30'h06, 32'h66, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 4'h0, 30'h01, 32'h11, 1'b1, 4'h0, 30'h07, 32'h77, 1'b1, 4'h0, 30'h07, 32'h77, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 4'h0, 30'h01, 32'h11, 1'b1, 4'hC, 30'h08, 32'h88, 1'b1, 4'hC, 30'h08, 32'h88, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'h0, 30'h09, 32'h99, 1'b1, 4'hF, 30'h0A, 32'hAA, 1'b1, 4'h0, 30'h09, 32'h99, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'h1, 30'h0B, 32'hBB, 1'b1, 4'h0, 30'h0C, 32'hCC, 1'b1, 4'h1, 30'h0B, 32'hBB, 1'b0, 1'b0};

        // Reset: requests present, but nothing may reach memory.
        reset_n = 1'b0;
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b1, 4'h0, 30'h20, 32'h0);
        tick();
        #1;
        checkOutput("rst_mem_ce", 32'(bus.mem_ce), 32'd0);
        checkOutput("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
        checkOutput("rst_core_stall", 32'(bus.core_stall), 32'd0);
        checkOutput("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        checkOutput("rst_host_q", bus.host_q, 32'd0);
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Grant/mux table, each vector followed by an idle cycle.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].cCe, vecs[v].cWe, vecs[v].cAddr, vecs[v].cD,
                          vecs[v].hReq, vecs[v].hWe, vecs[v].hAddr, vecs[v].hD);
            #1;
            checkOutput($sformatf("vec%0d_mem_ce", v), 32'(bus.mem_ce), 32'(vecs[v].eCe));
            checkOutput($sformatf("vec%0d_mem_we", v), 32'(bus.mem_we), 32'(vecs[v].eWe));
            checkOutput($sformatf("vec%0d_host_gnt", v), 32'(bus.host_gnt), 32'(vecs[v].eGnt));
            checkOutput($sformatf("vec%0d_core_stall", v), 32'(bus.core_stall), 32'(vecs[v].eStall));
            if (vecs[v].eCe) begin
                checkOutput($sformatf("vec%0d_mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].eAddr));
                checkOutput($sformatf("vec%0d_mem_d", v), bus.mem_d, vecs[v].eD);
            end
            tick();
            applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
            tick();
            tick();
        end

        // Core-only store then load.
        applyStimulus(1'b1, 4'hF, 30'h10, 32'hDEADBEEF, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        checkOutput("t1_sw_we", 32'(bus.mem_we), 32'hF);
        checkOutput("t1_sw_stall", 32'(bus.core_stall), 32'd0);
        tick();
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        checkOutput("t1_lw_stall", 32'(bus.core_stall), 32'd0);
        tick();
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        checkOutput("t1_core_q", bus.core_q, 32'hDEADBEEF);
        tick();

        // Host read while the core is idle.
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b1, 4'h0, 30'h20, 32'h0);
        #1;
        checkOutput("t2_gnt", 32'(bus.host_gnt), 32'd1);
        checkOutput("t2_addr", 32'(bus.mem_addr), 32'h20);
        tick();
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        checkOutput("t2_rvalid_early", 32'(bus.host_rvalid), 32'd0);
        tick();
        #1;
        checkOutput("t2_rvalid", 32'(bus.host_rvalid), 32'd1);
        checkOutput("t2_host_q", bus.host_q, 32'h12345678);
        tick();
        #1;
        checkOutput("t2_rvalid_pulse", 32'(bus.host_rvalid), 32'd0);

        // Core busy reading 0x10, host held reading 0x20: forced slot and read hold.
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b1, 4'h0, 30'h20, 32'h0);
        #1;
        runToForce("t3");
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        checkOutput("t3_resume_gnt", 32'(bus.host_gnt), 32'd0);
        checkOutput("t3_resume_stall", 32'(bus.core_stall), 32'd0);
        checkOutput("t3_resume_addr", 32'(bus.mem_addr), 32'h10);
        checkOutput("t4_core_q_held", bus.core_q, 32'hDEADBEEF);
        tick();
        #1;
        checkOutput("t3_host_rvalid", 32'(bus.host_rvalid), 32'd1);
        checkOutput("t3_host_q", bus.host_q, 32'h12345678);
        checkOutput("t4_core_q_after", bus.core_q, 32'hDEADBEEF);
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        tick();

        // Forced host store to the address the core keeps reading.
        applyStimulus(1'b1, 4'h0, 30'h30, 32'h0, 1'b1, 4'hF, 30'h30, 32'hA5A5A5A5);
        runToForce("t5");
        applyStimulus(1'b1, 4'h0, 30'h30, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        checkOutput("t5_core_q_held", bus.core_q, 32'h0);
        checkOutput("t5_reissue_addr", 32'(bus.mem_addr), 32'h30);
        tick();
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        #1;
        checkOutput("t5_core_q_new", bus.core_q, 32'hA5A5A5A5);
        checkOutput("t5_no_rvalid", 32'(bus.host_rvalid), 32'd0);
        tick();

        // Host withdraws its request before a grant: wait count restarts.
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b1, 4'h0, 30'h20, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        tick();
        #1;
        checkOutput("drop_no_rvalid", 32'(bus.host_rvalid), 32'd0);
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b1, 4'h0, 30'h20, 32'h0);
        runToForce("drop");
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        tick();
        tick();

        // Reset on the cycle after a host read grant.
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b1, 4'h0, 30'h20, 32'h0);
        #1;
        checkOutput("t6_gnt", 32'(bus.host_gnt), 32'd1);
        tick();
        reset_n = 1'b0;
        applyStimulus(1'b1, 4'h0, 30'h10, 32'h0, 1'b1, 4'h0, 30'h20, 32'h0);
        #1;
        checkOutput("t6_rst_mem_ce", 32'(bus.mem_ce), 32'd0);
        checkOutput("t6_rst_gnt", 32'(bus.host_gnt), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("t6_rvalid", 32'(bus.host_rvalid), 32'd0);
        checkOutput("t6_host_q", bus.host_q, 32'd0);
        runToForce("t6");
        #1;
        checkOutput("t6_rvalid_later", 32'(bus.host_rvalid), 32'd0);
        applyStimulus(1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 4'h0, 30'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
